// File: rtl/parser_ingress_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// parser_ingress_sched: frame-level round-robin arbiter sharing one N3/N6 parser
// across NUM_PORTS AXI-Stream ingress ports, with runaway-frame truncation.
// Revision: 1.0
//------------------------------------------------------------------------------
module parser_ingress_sched #(
   parameter int                   NUM_PORTS     = 4,
   parameter int                   DATA_W        = 512,
   parameter int                   MAX_PKT_BEATS = 32,
   parameter logic [NUM_PORTS-1:0] PORT_IS_N3    = 'b0011
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS-1:0]            port_en,
   input  logic [NUM_PORTS*DATA_W-1:0]     s_tdata,
   input  logic [NUM_PORTS*DATA_W/8-1:0]   s_tkeep,
   input  logic [NUM_PORTS-1:0]            s_tlast,
   input  logic [NUM_PORTS-1:0]            s_tvalid,
   output logic [NUM_PORTS-1:0]            s_tready,
   output logic [DATA_W-1:0]               m_tdata,
   output logic [DATA_W/8-1:0]             m_tkeep,
   output logic                            m_tlast,
   output logic                            m_tvalid,
   input  logic                            m_tready,
   output logic [$clog2(NUM_PORTS)-1:0]    m_port_id,
   output logic                            m_is_n3,
   output logic                            trunc_err,
   output logic                            busy
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam int KW = DATA_W / 8;
   localparam int CW = $clog2(MAX_PKT_BEATS + 1);
   localparam logic [CW-1:0] c_BEAT_LAST = CW'(MAX_PKT_BEATS - 1);
   localparam logic [CW-1:0] c_BEAT_SAT  = CW'(MAX_PKT_BEATS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                r_state;
   logic [PW-1:0]         r_gnt;
   logic [PW-1:0]         r_last_grant;
   logic [CW-1:0]         r_beat_cnt;
   logic [DATA_W-1:0]     r_m_tdata;
   logic [KW-1:0]         r_m_tkeep;
   logic                  r_m_tlast;
   logic                  r_m_tvalid;
   logic [PW-1:0]         r_m_port_id;
   logic                  r_m_is_n3;
   logic                  r_trunc_err;

   logic [NUM_PORTS-1:0]  w_req;
   logic [PW-1:0]         w_rr_gnt;
   logic                  w_rr_hit;
   logic [DATA_W-1:0]     w_data [NUM_PORTS];
   logic [KW-1:0]         w_keep [NUM_PORTS];
   logic                  w_sel_valid;
   logic                  w_sel_last;
   logic                  w_fwd_rdy;
   logic                  w_accept;

   generate
      for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slice
         assign w_data[i] = s_tdata[i*DATA_W +: DATA_W];
         assign w_keep[i] = s_tkeep[i*KW +: KW];
      end
   endgenerate

   assign w_req       = s_tvalid & port_en;
   assign w_sel_valid = s_tvalid[r_gnt];
   assign w_sel_last  = s_tlast[r_gnt];
   assign w_fwd_rdy   = ~r_m_tvalid | m_tready;

   // Search starts one past the previous winner so every requester is served in turn.
   always_comb begin : rr_search
      int idx;
      idx      = 0;
      w_rr_gnt = r_last_grant;
      w_rr_hit = 1'b0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx = (int'(r_last_grant) + i) % NUM_PORTS;
         if (!w_rr_hit && w_req[idx]) begin
            w_rr_gnt = PW'(idx);
            w_rr_hit = 1'b1;
         end
      end
   end

   always_comb begin
      s_tready = '0;
      if (r_state == XFER) begin
         s_tready[r_gnt] = w_fwd_rdy;
      end else if (r_state == DRAIN) begin
         s_tready[r_gnt] = 1'b1;
      end
   end

   assign w_accept = (r_state != IDLE) & w_sel_valid & s_tready[r_gnt];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_gnt        <= '0;
         r_last_grant <= PW'(NUM_PORTS - 1);
         r_beat_cnt   <= '0;
         r_m_tdata    <= '0;
         r_m_tkeep    <= '0;
         r_m_tlast    <= 1'b0;
         r_m_tvalid   <= 1'b0;
         r_m_port_id  <= '0;
         r_m_is_n3    <= 1'b0;
         r_trunc_err  <= 1'b0;
      end else begin
         r_trunc_err <= 1'b0;
         if (r_m_tvalid && m_tready) begin
            r_m_tvalid <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_rr_hit) begin
                  r_gnt        <= w_rr_gnt;
                  r_last_grant <= w_rr_gnt;
                  r_beat_cnt   <= '0;
                  r_state      <= XFER;
               end
            end
            XFER: begin
               if (w_accept) begin
                  r_m_tvalid  <= 1'b1;
                  r_m_tdata   <= w_data[r_gnt];
                  r_m_tkeep   <= w_keep[r_gnt];
                  r_m_tlast   <= w_sel_last;
                  r_m_port_id <= r_gnt;
                  r_m_is_n3   <= PORT_IS_N3[r_gnt];
                  if (r_beat_cnt != c_BEAT_SAT) begin
                     r_beat_cnt <= r_beat_cnt + 1'b1;
                  end
                  if (w_sel_last) begin
                     r_state <= IDLE;
                  end else if (r_beat_cnt == c_BEAT_LAST) begin
                     // Close the frame towards the parser; the rest is swallowed in DRAIN.
                     r_m_tlast   <= 1'b1;
                     r_trunc_err <= 1'b1;
                     r_state     <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (w_accept && w_sel_last) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign m_tdata   = r_m_tdata;
   assign m_tkeep   = r_m_tkeep;
   assign m_tlast   = r_m_tlast;
   assign m_tvalid  = r_m_tvalid;
   assign m_port_id = r_m_port_id;
   assign m_is_n3   = r_m_is_n3;
   assign trunc_err = r_trunc_err;
   assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_parser_ingress_sched.sv
`default_nettype none
// tb_parser_ingress_sched: table-driven frame vectors plus directed multi-cycle sequences.
module tb_parser_ingress_sched;

   localparam int NP   = 4;
   localparam int DW   = 32;
   localparam int KW   = DW / 8;
   localparam int MAXB = 32;

   logic               clk;
   logic               rst_n;
   logic [NP-1:0]      port_en;
   logic [NP*DW-1:0]   s_tdata;
   logic [NP*KW-1:0]   s_tkeep;
   logic [NP-1:0]      s_tlast;
   logic [NP-1:0]      s_tvalid;
   logic [NP-1:0]      s_tready;
   logic [DW-1:0]      m_tdata;
   logic [KW-1:0]      m_tkeep;
   logic               m_tlast;
   logic               m_tvalid;
   logic               m_tready;
   logic [1:0]         m_port_id;
   logic               m_is_n3;
   logic               trunc_err;
   logic               busy;

   parser_ingress_sched #(
      .NUM_PORTS(NP), .DATA_W(DW), .MAX_PKT_BEATS(MAXB), .PORT_IS_N3(4'b0011)
   ) dut (
      .clk(clk), .rst_n(rst_n), .port_en(port_en),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
      .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_port_id(m_port_id), .m_is_n3(m_is_n3),
      .trunc_err(trunc_err), .busy(busy)
   );

   typedef struct {
      int port;
      int nbeats;
      int exp_fwd;
      int exp_trunc;
      int exp_wait;
   } vec_t;

   typedef struct {
      int          pid;
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic        n3;
      int          cyc;
   } beat_t;

   vec_t  vecs [6];
   beat_t q [$];
   beat_t mon_b;
   int    nchecks, nerr;
   int    cyc, trunc_cnt, rdy2_cnt, stall_cnt;
   bit    abort, watch2;
   int    wa, wb, wc, wd;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      #2;
      if (m_tvalid && m_tready) begin
         mon_b.pid  = int'(m_port_id);
         mon_b.data = m_tdata;
         mon_b.keep = m_tkeep;
         mon_b.last = m_tlast;
         mon_b.n3   = m_is_n3;
         mon_b.cyc  = cyc;
         q.push_back(mon_b);
      end
      if (trunc_err) trunc_cnt++;
      if (watch2 && s_tready[2]) rdy2_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", nchecks, nerr);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mk_data(input int p, input int s, input int b);
      return {p[7:0], s[7:0], b[15:0]};
   endfunction

   function automatic logic [3:0] mk_keep(input int p, input int b);
      return 4'((b ^ p ^ 5) & 15);
   endfunction

   function automatic bit has_pid(input int p);
      foreach (q[i]) if (q[i].pid == p) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      nchecks++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drives one frame on port p; wait0 returns idle cycles before the first beat is taken.
   task automatic send_frame(input int p, input int seq, input int n, output int wait0);
      int w;
      bit acc;
      wait0 = 0;
      for (int b = 0; b < n; b++) begin
         s_tvalid[p]           = 1'b1;
         s_tdata[p*DW +: DW]   = mk_data(p, seq, b);
         s_tkeep[p*KW +: KW]   = mk_keep(p, b);
         s_tlast[p]            = (b == n - 1);
         w   = 0;
         acc = 1'b0;
         while (!acc && !abort && w <= 300) begin
            #1 acc = s_tready[p];
            @(posedge clk);
            @(negedge clk);
            if (!acc) w++;
         end
         if (b == 0) wait0 = w;
         if (w > 300) begin
            nchecks++;
            nerr++;
            $display("FAIL accept timeout: port %0d beat %0d got no ready, required ready", p, b);
         end
         if (abort || w > 300) break;
      end
      s_tvalid[p] = 1'b0;
      s_tlast[p]  = 1'b0;
   endtask

   task automatic two_frames(input int p);
      int w;
      send_frame(p, 0, 2, w);
      send_frame(p, 1, 2, w);
   endtask

   task automatic verify_frame(input int base, input int p, input int seq, input int n);
      for (int i = 0; i < n; i++) begin
         if (base + i < q.size()) begin
            check("beat port_id", q[base+i].pid, p);
            check("beat is_n3", q[base+i].n3, (p < 2) ? 1 : 0);
            check("beat data", q[base+i].data, mk_data(p, seq, i));
            check("beat keep", q[base+i].keep, mk_keep(p, i));
            check("beat tlast", q[base+i].last, (i == n - 1) ? 1 : 0);
         end
      end
   endtask

   task automatic check_zero();
      check("rst m_tvalid", m_tvalid, 0);
      check("rst m_tlast", m_tlast, 0);
      check("rst m_tdata", m_tdata, 0);
      check("rst m_tkeep", m_tkeep, 0);
      check("rst m_port_id", m_port_id, 0);
      check("rst m_is_n3", m_is_n3, 0);
      check("rst trunc_err", trunc_err, 0);
      check("rst busy", busy, 0);
      check("rst s_tready", s_tready, 0);
   endtask

   initial begin
      rst_n = 1'b0; port_en = '1; s_tvalid = '0; s_tlast = '0;
      s_tdata = '0; s_tkeep = '0; m_tready = 1'b1;
      abort = 1'b0; watch2 = 1'b0; nchecks = 0; nerr = 0;
      cyc = 0; trunc_cnt = 0; rdy2_cnt = 0; stall_cnt = 0;

      vecs[0] = '{port:2, nbeats:3,  exp_fwd:3,  exp_trunc:0, exp_wait:1};
      vecs[1] = '{port:0, nbeats:1,  exp_fwd:1,  exp_trunc:0, exp_wait:1};
      vecs[2] = '{port:3, nbeats:32, exp_fwd:32, exp_trunc:0, exp_wait:1};
      vecs[3] = '{port:0, nbeats:2,  exp_fwd:2,  exp_trunc:0, exp_wait:1};
      vecs[4] = '{port:1, nbeats:33, exp_fwd:32, exp_trunc:1, exp_wait:1};
      vecs[5] = '{port:1, nbeats:40, exp_fwd:32, exp_trunc:1, exp_wait:1};

      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check_zero();
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         q.delete();
         trunc_cnt = 0;
         send_frame(vecs[v].port, v, vecs[v].nbeats, wa);
         repeat (4) @(negedge clk);
         check("first-beat wait", wa, vecs[v].exp_wait);
         check("forwarded beats", q.size(), vecs[v].exp_fwd);
         verify_frame(0, vecs[v].port, v, vecs[v].exp_fwd);
         check("trunc pulses", trunc_cnt, vecs[v].exp_trunc);
         check("busy after frame", busy, 0);
      end

      // After port 1 was served, port 2 outranks port 0.
      q.delete();
      fork
         send_frame(0, 9, 1, wa);
         send_frame(2, 9, 1, wb);
      join
      repeat (4) @(negedge clk);
      check("post-trunc count", q.size(), 2);
      if (q.size() == 2) begin
         check("post-trunc first grant", q[0].pid, 2);
         check("post-trunc second grant", q[1].pid, 0);
      end

      // Round robin over all four ports from a fresh reset.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      fork
         two_frames(0);
         two_frames(1);
         two_frames(2);
         two_frames(3);
      join
      repeat (4) @(negedge clk);
      check("rr beat count", q.size(), 16);
      for (int f = 0; f < 8; f++) begin
         verify_frame(2*f, f % 4, f / 4, 2);
         if (f > 0 && 2*f < q.size()) check("rr frame spacing", q[2*f].cyc - q[2*f-2].cyc, 3);
      end

      // Port 2 disabled; port 3 loses its enable mid-frame.
      q.delete();
      port_en = 4'b1011;
      rdy2_cnt = 0;
      watch2 = 1'b1;
      s_tvalid[2] = 1'b1;
      s_tdata[2*DW +: DW] = 32'hDEAD_0002;
      fork
         send_frame(0, 2, 2, wa);
         send_frame(1, 2, 2, wb);
         send_frame(3, 2, 4, wc);
         begin
            for (int k = 0; k < 200 && !has_pid(3); k++) @(negedge clk);
            port_en[3] = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      watch2 = 1'b0;
      s_tvalid[2] = 1'b0;
      port_en = '1;
      check("port_en beat count", q.size(), 8);
      verify_frame(0, 0, 2, 2);
      verify_frame(2, 1, 2, 2);
      verify_frame(4, 3, 2, 4);
      check("disabled port ready", rdy2_cnt, 0);

      // Back-pressure 1,0,0,1 on a 4-beat frame from port 0.
      q.delete();
      stall_cnt = 0;
      fork
         send_frame(0, 3, 4, wd);
         begin
            logic [31:0] held;
            bit stalled;
            logic [7:0] pat;
            pat = 8'b1111_1001;
            stalled = 1'b0;
            held = '0;
            for (int i = 0; i < 100 && !m_tvalid; i++) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
               m_tready = pat[k];
               #1;
               if (stalled) check("stall data hold", m_tdata, held);
               if (m_tvalid && !m_tready) begin
                  check("stall s_tready", s_tready[0], 0);
                  held = m_tdata;
                  stalled = 1'b1;
                  stall_cnt++;
               end else begin
                  stalled = 1'b0;
               end
               @(negedge clk);
            end
            m_tready = 1'b1;
         end
      join
      repeat (4) @(negedge clk);
      check("stall cycles", stall_cnt, 2);
      check("stall beat count", q.size(), 4);
      verify_frame(0, 0, 3, 4);

      // Reset during beat 2 of a 5-beat frame on port 1.
      q.delete();
      fork
         send_frame(1, 4, 5, wa);
         begin
            for (int k = 0; k < 100 && q.size() < 2; k++) @(negedge clk);
            rst_n = 1'b0;
            abort = 1'b1;
            @(negedge clk); #1;
            check_zero();
            @(negedge clk);
            rst_n = 1'b1;
         end
      join
      abort = 1'b0;
      q.delete();
      fork
         send_frame(0, 5, 1, wa);
         send_frame(1, 5, 1, wb);
      join
      repeat (4) @(negedge clk);
      check("post-reset count", q.size(), 2);
      if (q.size() == 2) begin
         check("post-reset first grant", q[0].pid, 0);
         check("post-reset second grant", q[1].pid, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
`default_nettype wire
